// File: rtl/clownfish_l2_pkg.sv
// rtl/clownfish_l2_pkg.sv - shared L2 SRAM bank geometry constants
package clownfish_l2_pkg;

  localparam int L2_SRAM_DATA_WIDTH = 64;
  localparam int L2_SRAM_ADDR_WIDTH = 9;
  localparam int L2_SRAM_NUM_WMASK  = L2_SRAM_DATA_WIDTH / 8;

  typedef logic [L2_SRAM_DATA_WIDTH-1:0] l2_sram_word_t;
  typedef logic [L2_SRAM_ADDR_WIDTH-1:0] l2_sram_addr_t;
  typedef logic [L2_SRAM_NUM_WMASK-1:0]  l2_sram_wmask_t;

endpackage

// File: rtl/l2_sram_byte_merge.sv
// rtl/l2_sram_byte_merge.sv - combinational byte-lane merge of write data into an old word
module l2_sram_byte_merge
  import clownfish_l2_pkg::*;
#(
  parameter int DATA_WIDTH = L2_SRAM_DATA_WIDTH,
  parameter int NUM_WMASK  = L2_SRAM_NUM_WMASK
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [NUM_WMASK-1:0]  wmask,
  output logic [DATA_WIDTH-1:0] merged
);

  // Each set mask bit replaces its byte lane; cleared lanes keep the old byte.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < NUM_WMASK; i++) begin
      if (wmask[i]) begin
        merged[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/l2_cache_way_sram.sv
// rtl/l2_cache_way_sram.sv - 512x64 single-port L2 way SRAM bank; L2_SRAM_WRITE_FIRST_EN selects write-first dout
module l2_cache_way_sram
  import clownfish_l2_pkg::*;
#(
  parameter int DATA_WIDTH = L2_SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = L2_SRAM_ADDR_WIDTH,
  parameter int NUM_WMASK  = L2_SRAM_NUM_WMASK
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASK-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Behavioural array; stands in for the OpenRAM macro with the same ports.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  do_access;

  assign rd_word   = mem[addr0];
  assign do_access = rst_n && !csb0;

  l2_sram_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WMASK  (NUM_WMASK)
  ) u_byte_merge (
    .old_word (rd_word),
    .din      (din0),
    .wmask    (wmask0),
    .merged   (merged_word)
  );

  // Array write: read-modify-write of the addressed word; dropped while in reset.
  always_ff @(posedge clk0) begin
    if (do_access && !web0) begin
      mem[addr0] <= merged_word;
    end
  end

  // Registered read port; reset clears it immediately, idle cycles hold it.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      dout0 <= '0;
    end else if (!csb0) begin
      if (web0) begin
        dout0 <= rd_word;
      end else begin
`ifdef L2_SRAM_WRITE_FIRST_EN
        dout0 <= merged_word;
`else
        dout0 <= dout0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_l2_cache_way_sram.sv
// tb/tb_l2_cache_way_sram.sv - self-checking bench for l2_cache_way_sram
module tb_l2_cache_way_sram;

  logic        clk0 = 1'b0;
  logic        rst_n = 1'b0;
  logic        csb0 = 1'b1;
  logic        web0 = 1'b1;
  logic [7:0]  wmask0 = '0;
  logic [8:0]  addr0 = '0;
  logic [63:0] din0 = '0;
  logic [63:0] dout0;

  l2_cache_way_sram dut (
    .clk0   (clk0),
    .rst_n  (rst_n),
    .csb0   (csb0),
    .web0   (web0),
    .wmask0 (wmask0),
    .addr0  (addr0),
    .din0   (din0),
    .dout0  (dout0)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    logic        csb;
    logic        web;
    logic [7:0]  wmask;
    logic [8:0]  addr;
    logic [63:0] din;
    logic        chk;
    logic [63:0] exp;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] model_mem [512];
  logic [63:0] model_dout = '0;
  logic [63:0] exp_q [$];
  vec_t        vecs [11];

  function automatic logic [63:0] fill_pat(input int a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dout0=%016h required %016h", name, act, exp);
    end
  endtask

  task automatic do_cycle(input logic c, input logic w, input logic [7:0] m,
                          input logic [8:0] a, input logic [63:0] d, input string name);
    logic [63:0] e;
    @(negedge clk0);
    csb0 = c; web0 = w; wmask0 = m; addr0 = a; din0 = d;
    if (rst_n && !c) begin
      if (w) begin
        model_dout = model_mem[a];
      end else begin
`ifdef L2_SRAM_WRITE_FIRST_EN
        model_dout = merge(model_mem[a], d, m);
`endif
        model_mem[a] = merge(model_mem[a], d, m);
      end
    end
    if (!rst_n) model_dout = '0;
    exp_q.push_back(model_dout);
    @(posedge clk0);
    #1;
    e = exp_q.pop_front();
    check(name, dout0, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 512; i++) model_mem[i] = '0;

    // csb, web, wmask, addr, din, chk, exp
    vecs[0]  = '{1'b0, 1'b0, 8'hFF, 9'h1FF, 64'h0123456789ABCDEF, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 9'h1FF, 64'h0,                1'b1, 64'h0123456789ABCDEF};
    vecs[2]  = '{1'b0, 1'b0, 8'hFF, 9'h005, 64'h1111111111111111, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 1'b0, 8'h0F, 9'h005, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 1'b1, 8'hFF, 9'h005, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h11111111AAAAAAAA};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 9'h009, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 9'h009, 64'h0,                1'b1, 64'hA5A5000000000009};
    vecs[7]  = '{1'b0, 1'b0, 8'h81, 9'h010, 64'hFFEEDDCCBBAA9988, 1'b0, 64'h0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 9'h010, 64'h0,                1'b1, 64'hFFA5000000000088};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 9'h000, 64'h0,                1'b1, 64'hA5A5000000000000};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 9'h1FF, 64'h0,                1'b1, 64'h0123456789ABCDEF};

    // Reset state
    #1;
    check("reset_dout", dout0, 64'h0);
    @(posedge clk0);
    @(posedge clk0);
    #1;
    rst_n = 1'b1;

    // Known contents everywhere
    for (int a = 0; a < 512; a++) do_cycle(1'b0, 1'b0, 8'hFF, 9'(a), fill_pat(a), "fill");

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      do_cycle(vecs[i].csb, vecs[i].web, vecs[i].wmask, vecs[i].addr, vecs[i].din,
               $sformatf("vec%0d", i));
      if (vecs[i].chk) check($sformatf("vec%0d_table", i), dout0, vecs[i].exp);
    end

    // Idle hold with random inputs
    do_cycle(1'b0, 1'b1, 8'h00, 9'h1FF, 64'h0, "idle_pre_read");
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 9'($urandom),
               {$urandom, $urandom}, "idle_hold");
      check("idle_hold_table", dout0, 64'h0123456789ABCDEF);
    end
    for (int a = 0; a < 512; a++) do_cycle(1'b0, 1'b1, 8'h00, 9'(a), 64'h0, "idle_array");

    // Read-during-write
    do_cycle(1'b0, 1'b1, 8'h00, 9'h020, 64'h0, "rdw_read");
    do_cycle(1'b0, 1'b0, 8'h3C, 9'h020, 64'h1122334455667788, "rdw_write");
`ifdef L2_SRAM_WRITE_FIRST_EN
    check("rdw_write_table", dout0, 64'hA5A5334455660020);
`else
    check("rdw_write_table", dout0, 64'hA5A5000000000020);
`endif
    do_cycle(1'b0, 1'b1, 8'h00, 9'h020, 64'h0, "rdw_next_read");
    check("rdw_next_read_table", dout0, 64'hA5A5334455660020);

    // Asynchronous reset clears dout0 before any edge
    do_cycle(1'b0, 1'b0, 8'hFF, 9'h030, 64'hDEADBEEFCAFEF00D, "rst_setup_wr");
    do_cycle(1'b0, 1'b1, 8'h00, 9'h030, 64'h0, "rst_setup_rd");
    check("rst_setup_table", dout0, 64'hDEADBEEFCAFEF00D);
    #2;
    rst_n = 1'b0;
    model_dout = '0;
    #1;
    check("async_reset", dout0, 64'h0);

    // Write during reset is dropped
    do_cycle(1'b0, 1'b0, 8'hFF, 9'h007, 64'hFFFFFFFFFFFFFFFF, "wr_in_reset");
    do_cycle(1'b0, 1'b1, 8'h00, 9'h030, 64'h0, "rd_in_reset");
    #1;
    rst_n = 1'b1;
    do_cycle(1'b0, 1'b1, 8'h00, 9'h007, 64'h0, "post_reset_rd7");
    check("post_reset_rd7_table", dout0, 64'hA5A5000000000007);
    do_cycle(1'b0, 1'b1, 8'h00, 9'h030, 64'h0, "post_reset_rd30");
    check("post_reset_rd30_table", dout0, 64'hDEADBEEFCAFEF00D);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_cache_way_sram.md
# l2_cache_way_sram

Single-port synchronous SRAM bank holding one 64-bit word slice of one L2 way. It is 512 entries × 64 bits with a per-byte write mask and active-low chip-select and write-enable. The L2 cache instantiates 8 × 8 copies, one per (way, word-of-line). Each copy is indexed by the set index and serves tag-check reads, write-hit writes, writeback reads and refill writes.

## Interface
Parameters:
- DATA_WIDTH, 64: word width in bits.
- ADDR_WIDTH, 9: address width. Depth is 2^ADDR_WIDTH = 512.
- NUM_WMASK, 8: number of byte-lane write-mask bits (DATA_WIDTH/8).

Ports:
- clk0, input, 1: the single clock, rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- csb0, input, 1: chip select, active low. 1 means no access.
- web0, input, 1: write enable, active low. 0 means write, 1 means read.
- wmask0, input, NUM_WMASK: byte-lane write mask. Bit i covers din0[8i+7:8i].
- addr0, input, ADDR_WIDTH: word address.
- din0, input, DATA_WIDTH: write data.
- dout0, output, DATA_WIDTH: registered read data.

## Operation
- Storage is 2^ADDR_WIDTH words of DATA_WIDTH bits. Every address is in range, so there is no wrap-around or error case.
- Idle (csb0=1): no access. The array is unchanged and dout0 holds its value.
- Read (csb0=0, web0=1): dout0 is loaded with mem[addr0]. wmask0 and din0 are ignored.
- Write (csb0=0, web0=0): for each i where wmask0[i]=1, mem[addr0] byte i is set to din0 byte i. Bytes with a 0 mask bit keep their old value. wmask0=0 is a legal no-op write.
- dout0 on a write cycle: holds its previous value unless the write-first option is enabled (see Configuration).
- Reset clears dout0 only. Array contents are not reset and are power-up undefined; simulation models initialise them to 0.
- No ordering exists between ports. Every access completes on the edge at which it is sampled.

## Timing
- Inputs are sampled on the rising edge of clk0. Read latency is 1 cycle: with a read at edge N, dout0 carries mem[addr0] after edge N and until the next read, enabled write-first write, or reset.
- A write is visible to a read at edge N+1 or later.
- A read at edge N of an address written at edge N−1 returns the new data.
- Reset value of dout0 is 0. Assertion of rst_n clears dout0 immediately, without waiting for a clock edge.
- While rst_n=0, edges perform no access. Any write sampled while rst_n=0 is dropped and the array is unchanged.
- Reset asserted mid-sequence: accesses already completed persist. The first access after deassertion is at the first rising edge with rst_n=1.
- No handshake: the bank is always ready, and one access is possible every cycle.

## Configuration
- L2_SRAM_WRITE_FIRST_EN defined: on a write cycle, dout0 is loaded with the merged word (new bytes where the mask is 1, old bytes elsewhere). This gives write-first read-during-write behaviour.
- L2_SRAM_WRITE_FIRST_EN undefined (default): dout0 holds its previous value on write cycles, matching OpenRAM macro behaviour.

## Structure
- Shared package clownfish_l2_pkg holds L2_SRAM_DATA_WIDTH=64, L2_SRAM_ADDR_WIDTH=9 and L2_SRAM_NUM_WMASK=8. The cache top and this bank both use these constants.
- One sub-module, l2_sram_byte_merge. It is combinational: from (old word, din0, wmask0) it produces the merged word. The write path uses it, and the write-first dout path uses it when enabled.
- The array is a single behavioural memory, replaceable by the OpenRAM macro of identical port list for hardening.

## Test plan
- Reset: drive rst_n=0 with dout0 previously 0xDEADBEEF_CAFEF00D. Required: dout0=0 immediately, before any clock edge.
- Full-word write then read: write addr 0x1FF, din 0x0123456789ABCDEF, wmask 0xFF, then read addr 0x1FF. Required: dout0=0x0123456789ABCDEF one cycle after the read edge.
- Partial mask:
  - Write addr 5 with 0x1111111111111111 and mask 0xFF.
  - Then write 0xAAAAAAAAAAAAAAAA with mask 0x0F.
  - Then read addr 5.
  - Required: dout0=0x11111111AAAAAAAA.
- Idle hold: after a read leaves dout0=0x0123456789ABCDEF, hold csb0=1 with random addr/din/web for 5 cycles. Required: dout0 unchanged and no array change at any address.
- Write during reset: write addr 7 with 0xFFFFFFFFFFFFFFFF while rst_n=0, then deassert reset and read addr 7. Required: the prior content of addr 7 is returned.
- Read-during-write on a write edge with dout0=X:
  - Default build: dout0 stays X.
  - L2_SRAM_WRITE_FIRST_EN build: dout0 shows the merged word.
